// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin arbiter that shares one 4:1 data path between four requesters.
// Bursts are bounded, and a registered valid/ready stage drives the output.
module mux_4to1_rr_arbiter #(
   parameter int n         = 8,
   parameter int MAX_BURST = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   req,
   input  logic [n-1:0] q0,
   input  logic [n-1:0] q1,
   input  logic [n-1:0] q2,
   input  logic [n-1:0] q3,
   input  logic         out_ready,
   output logic [3:0]   gnt,
   output logic [1:0]   sel,
   output logic         en,
   output logic [n-1:0] d,
   output logic         d_valid,
   output logic         busy
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

   state_t       state_q, state_d;
   logic [1:0]   last_q, last_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [3:0]   gnt_q, gnt_d;
   logic [1:0]   sel_q, sel_d;
   logic         en_q, en_d;
   logic         busy_q, busy_d;
   logic [n-1:0] d_q, d_d;
   logic         dv_q, dv_d;

   logic [n-1:0] q_sel_s;
   logic [1:0]   win_s;
   logic [1:0]   idx_s;
   logic         found_s;
   logic         beat_s;

   // Data-path mux driven by the registered owner index
   always_comb begin
      q_sel_s = q0;
      case (sel_q)
         2'd0:    q_sel_s = q0;
         2'd1:    q_sel_s = q1;
         2'd2:    q_sel_s = q2;
         2'd3:    q_sel_s = q3;
         default: q_sel_s = q0;
      endcase
   end

   // Round-robin search starting one past the last owner; k=4 wraps to last
   always_comb begin
      win_s   = 2'd0;
      found_s = 1'b0;
      idx_s   = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         idx_s = last_q + 2'(k);
         if (!found_s && req[idx_s]) begin
            win_s   = idx_s;
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   assign beat_s = (state_q == GRANT) && req[sel_q] && (!dv_q || out_ready);

   // Next-state: arbitration FSM plus the independent output drain
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      en_d    = en_q;
      busy_d  = busy_q;
      d_d     = d_q;
      dv_d    = dv_q;

      case (state_q)
         IDLE: begin
            gnt_d  = 4'b0000;
            en_d   = 1'b0;
            busy_d = 1'b0;
            if (found_s) begin
               gnt_d   = 4'b0001 << win_s;
               sel_d   = win_s;
               en_d    = 1'b1;
               busy_d  = 1'b1;
               cnt_d   = 4'd0;
               state_d = GRANT;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            if (beat_s) begin
               cnt_d = cnt_q + 4'd1;
            end else begin
               cnt_d = cnt_q;
            end
            if ((beat_s && (cnt_q + 4'd1 == MAX_CNT)) || !req[sel_q]) begin
               last_d  = sel_q;
               gnt_d   = 4'b0000;
               en_d    = 1'b0;
               busy_d  = 1'b0;
               cnt_d   = 4'd0;
               state_d = IDLE;
            end else begin
               state_d = GRANT;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = 4'd0;
         end
      endcase

      // A beat refills d even when the old beat is consumed this same cycle
      if (beat_s) begin
         d_d  = q_sel_s;
         dv_d = 1'b1;
      end else if (dv_q && out_ready) begin
         dv_d = 1'b0;
      end else begin
         dv_d = dv_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         last_q  <= 2'd3;
         cnt_q   <= 4'd0;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'd0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         d_q     <= '0;
         dv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         d_q     <= d_d;
         dv_q    <= dv_d;
      end
   end

   assign gnt     = gnt_q;
   assign sel     = sel_q;
   assign en      = en_q;
   assign busy    = busy_q;
   assign d       = d_q;
   assign d_valid = dv_q;

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// Scoreboard bench: three arbiters (MAX_BURST 4, 2, 1) run one at a time;
// directed stimulus queues expected beats and grants, a negedge monitor pops them.
module tb_mux_4to1_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] req_a = 4'd0, req_b = 4'd0, req_c = 4'd0;
   logic [7:0] q0 = 8'd0, q1 = 8'd0, q2 = 8'd0, q3 = 8'd0;
   logic       out_ready = 1'b1;

   logic [3:0] gnt_a, gnt_b, gnt_c;
   logic [1:0] sel_a, sel_b, sel_c;
   logic       en_a, en_b, en_c, dv_a, dv_b, dv_c, busy_a, busy_b, busy_c;
   logic [7:0] d_a, d_b, d_c;

   logic [3:0] m_gnt;
   logic [1:0] m_sel;
   logic       m_en, m_dv, m_busy;
   logic [7:0] m_d;
   int         act = 0;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_d[$];
   logic [3:0] exp_g[$];
   logic [3:0] prev_gnt = 4'd0;

   always #5 clk = ~clk;

   mux_4to1_rr_arbiter #(.n(8), .MAX_BURST(4)) dut_a (
      .clk(clk), .rst(rst), .req(req_a), .q0(q0), .q1(q1), .q2(q2), .q3(q3),
      .out_ready(out_ready), .gnt(gnt_a), .sel(sel_a), .en(en_a), .d(d_a),
      .d_valid(dv_a), .busy(busy_a));
   mux_4to1_rr_arbiter #(.n(8), .MAX_BURST(2)) dut_b (
      .clk(clk), .rst(rst), .req(req_b), .q0(q0), .q1(q1), .q2(q2), .q3(q3),
      .out_ready(out_ready), .gnt(gnt_b), .sel(sel_b), .en(en_b), .d(d_b),
      .d_valid(dv_b), .busy(busy_b));
   mux_4to1_rr_arbiter #(.n(8), .MAX_BURST(1)) dut_c (
      .clk(clk), .rst(rst), .req(req_c), .q0(q0), .q1(q1), .q2(q2), .q3(q3),
      .out_ready(out_ready), .gnt(gnt_c), .sel(sel_c), .en(en_c), .d(d_c),
      .d_valid(dv_c), .busy(busy_c));

   always_comb begin
      case (act)
         1: begin m_gnt = gnt_b; m_sel = sel_b; m_en = en_b; m_dv = dv_b; m_busy = busy_b; m_d = d_b; end
         2: begin m_gnt = gnt_c; m_sel = sel_c; m_en = en_c; m_dv = dv_c; m_busy = busy_c; m_d = d_c; end
         default: begin m_gnt = gnt_a; m_sel = sel_a; m_en = en_a; m_dv = dv_a; m_busy = busy_a; m_d = d_a; end
      endcase
   end

   task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
      end
   endtask

   task automatic step(input int k = 1);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int which);
      req_a = 4'd0; req_b = 4'd0; req_c = 4'd0;
      out_ready = 1'b1;
      rst = 1'b0;
      step(2);
      act = which;
      rst = 1'b1;
      step(1);
   endtask

   // Monitor: consumed beats and new grants against the scoreboard, plus invariants
   always @(negedge clk) begin
      if (m_dv && out_ready) begin
         if (exp_d.size() == 0) begin
            checks++; errors++;
            $display("FAIL data_unexpected actual=%0h required=none", m_d);
         end else begin
            chk("data", {24'd0, m_d}, {24'd0, exp_d.pop_front()});
         end
      end
      if (m_gnt != prev_gnt && m_gnt != 4'd0) begin
         if (exp_g.size() == 0) begin
            checks++; errors++;
            $display("FAIL grant_unexpected actual=%0h required=none", m_gnt);
         end else begin
            chk("grant_order", {28'd0, m_gnt}, {28'd0, exp_g.pop_front()});
         end
      end
      prev_gnt = m_gnt;
      chk("invariant", {31'd0, ((m_gnt & (m_gnt - 4'd1)) == 4'd0) && (m_en == (m_gnt != 4'd0))
                                && (m_busy == m_en) && (!m_en || m_gnt[m_sel])}, 32'd1);
   end

   initial begin
      // Reset state
      rst = 1'b0;
      #2;
      chk("rst_gnt", {28'd0, m_gnt}, 32'd0);
      chk("rst_en_busy_dv", {29'd0, m_en, m_busy, m_dv}, 32'd0);
      chk("rst_d_sel", {22'd0, m_sel, m_d}, 32'd0);

      // Sole requester, MAX_BURST=4
      do_reset(0);
      req_a = 4'b0001; q0 = 8'hA1;
      repeat (4) exp_d.push_back(8'hA1);
      exp_g.push_back(4'b0001); exp_g.push_back(4'b0001);
      chk("t1_pre_grant", {28'd0, m_gnt}, 32'd0);
      step();
      chk("t1_grant", {28'd0, m_gnt}, 32'd1);
      chk("t1_en_busy", {30'd0, m_en, m_busy}, 32'd3);
      step();
      chk("t1_first_beat", {23'd0, m_dv, m_d}, {23'd0, 1'b1, 8'hA1});
      step(3);
      chk("t1_bubble", {27'd0, m_dv, m_gnt}, {27'd0, 1'b1, 4'b0000});
      step();
      chk("t1_regrant", {28'd0, m_gnt}, 32'd1);
      req_a = 4'd0;
      step();
      chk("t1_drop", {28'd0, m_gnt}, 32'd0);

      // All four requesting, MAX_BURST=2
      do_reset(1);
      req_b = 4'b1111; q0 = 8'h11; q1 = 8'h22; q2 = 8'h33; q3 = 8'h44;
      foreach (q0[i]) begin end
      exp_d.push_back(8'h11); exp_d.push_back(8'h11); exp_d.push_back(8'h22); exp_d.push_back(8'h22);
      exp_d.push_back(8'h33); exp_d.push_back(8'h33); exp_d.push_back(8'h44); exp_d.push_back(8'h44);
      exp_g.push_back(4'b0001); exp_g.push_back(4'b0010); exp_g.push_back(4'b0100);
      exp_g.push_back(4'b1000); exp_g.push_back(4'b0001);
      step(3);
      chk("t2_bubble", {28'd0, m_gnt}, 32'd0);
      step();
      chk("t2_second_grant", {28'd0, m_gnt}, 32'd2);
      step(9);
      chk("t2_wrap_grant", {28'd0, m_gnt}, 32'd1);
      req_b = 4'd0;
      step(2);

      // Backpressure on owner 2, MAX_BURST=4
      do_reset(0);
      req_a = 4'b0100; q2 = 8'h33;
      exp_d.push_back(8'h33);
      repeat (3) exp_d.push_back(8'h34);
      exp_g.push_back(4'b0100);
      step(2);
      out_ready = 1'b0;
      step(5);
      chk("t3_hold_d", {23'd0, m_dv, m_d}, {23'd0, 1'b1, 8'h33});
      chk("t3_hold_gnt", {28'd0, m_gnt}, 32'd4);
      out_ready = 1'b1; q2 = 8'h34;
      step(2);
      chk("t3_mid_burst", {28'd0, m_gnt}, 32'd4);
      step();
      chk("t3_release", {28'd0, m_gnt}, 32'd0);
      req_a = 4'd0;
      step(2);

      // Owner 1 drops mid-burst; requester 3 wins over 0 next
      do_reset(0);
      req_a = 4'b1010; q1 = 8'h55; q3 = 8'h77;
      exp_d.push_back(8'h55); exp_d.push_back(8'h55);
      repeat (4) exp_d.push_back(8'h77);
      exp_g.push_back(4'b0010); exp_g.push_back(4'b1000); exp_g.push_back(4'b0001);
      step();
      chk("t4_grant1", {28'd0, m_gnt}, 32'd2);
      step(2);
      req_a = 4'b1000;
      step();
      chk("t4_release", {28'd0, m_gnt}, 32'd0);
      req_a = 4'b1001;
      step();
      chk("t4_grant3", {28'd0, m_gnt}, 32'd8);
      step(5);
      chk("t4_grant0", {28'd0, m_gnt}, 32'd1);
      req_a = 4'd0;
      step(2);

      // Asynchronous reset mid-burst
      do_reset(0);
      req_a = 4'b0001; q0 = 8'h66;
      exp_g.push_back(4'b0001); exp_g.push_back(4'b0010);
      step(2);
      #2 rst = 1'b0;
      #1;
      chk("t5_async_gnt_sel", {26'd0, m_sel, m_gnt}, 32'd0);
      chk("t5_async_d", {21'd0, m_en, m_busy, m_dv, m_d}, 32'd0);
      req_a = 4'b0110; q1 = 8'h88;
      step();
      rst = 1'b1;
      step();
      chk("t5_first_grant", {28'd0, m_gnt}, 32'd2);
      req_a = 4'd0;
      step(2);

      // MAX_BURST=1, two requesters alternate
      do_reset(2);
      req_c = 4'b0101; q0 = 8'hC0; q2 = 8'hC2;
      exp_d.push_back(8'hC0); exp_d.push_back(8'hC2); exp_d.push_back(8'hC0); exp_d.push_back(8'hC2);
      exp_g.push_back(4'b0001); exp_g.push_back(4'b0100); exp_g.push_back(4'b0001); exp_g.push_back(4'b0100);
      step(2);
      chk("t6_bubble", {23'd0, m_dv, m_gnt}, {23'd0, 1'b1, 4'b0000});
      step();
      chk("t6_alt_grant", {28'd0, m_gnt}, 32'd4);
      step(5);
      req_c = 4'd0;
      step(3);

      chk("exp_d_drained", exp_d.size(), 32'd0);
      chk("exp_g_drained", exp_g.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
